// File: rtl/hpdcache_rsp_demux_pkg.sv
// Shared width helpers and types for the hpdcache response demux slice.
package hpdcache_rsp_demux_pkg;

  // Index width for n requesters, never below 1 bit so a single requester still has a type.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hpdcache_rsp_demux_if.sv
// Request-tracking and response-routing bundle between the arbiter/memory side and the demux.
interface hpdcache_rsp_demux_if
  import hpdcache_rsp_demux_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [N-1:0]      req_gnt_i;
  logic              req_fire_i;
  logic              full_o;
  logic              empty_o;
  logic [CNT_W-1:0]  count_o;
  logic              rsp_valid_i;
  logic              rsp_ready_o;
  logic              rsp_last_i;
  logic [DATA_W-1:0] rsp_data_i;
  logic [N-1:0]      rsp_valid_o;
  logic [N-1:0]      rsp_ready_i;
  logic [DATA_W-1:0] rsp_data_o;
  logic              err_o;

  modport master (
    output req_gnt_i, req_fire_i, rsp_valid_i, rsp_last_i, rsp_data_i, rsp_ready_i,
    input  full_o, empty_o, count_o, rsp_ready_o, rsp_valid_o, rsp_data_o, err_o
  );

  modport slave (
    input  req_gnt_i, req_fire_i, rsp_valid_i, rsp_last_i, rsp_data_i, rsp_ready_i,
    output full_o, empty_o, count_o, rsp_ready_o, rsp_valid_o, rsp_data_o, err_o
  );
endinterface

// File: rtl/hpdcache_1hot_to_binary.sv
// Grant vector to requester index; lowest set bit wins, all-zero encodes to 0.
// Purely combinational, no backpressure.
module hpdcache_1hot_to_binary
  import hpdcache_rsp_demux_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]              onehot,
  output logic [idx_width(N)-1:0]   bin
);
  localparam int unsigned W = idx_width(N);

  always_comb begin
    bin = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) bin = W'(i);
    end
  end
endmodule

// File: rtl/hpdcache_rsp_demux.sv
// Records grant order of accepted requests and routes the in-order response stream back.
// Routing is zero-latency; a pushed entry reaches the head one cycle later.
// Stalls the shared response while empty or while the head requester is not ready.
// Optional checker: define HPDCACHE_RSP_DEMUX_CHECK_EN for sticky err_o and assertions.
module hpdcache_rsp_demux
  import hpdcache_rsp_demux_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hpdcache_rsp_demux_if.slave  bus
);
  localparam int unsigned IDX_W = idx_width(N);
  localparam int unsigned PTR_W = idx_width(DEPTH);
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  typedef logic [IDX_W-1:0] hpdcache_req_idx_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  hpdcache_req_idx_t idx_q [DEPTH];
  hpdcache_req_idx_t gnt_idx;
  hpdcache_req_idx_t head;
  ptr_t              rd_ptr_q, wr_ptr_q;
  cnt_t              cnt_q;
  logic              empty, full, push, pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  hpdcache_1hot_to_binary #(.N(N)) u_gnt_enc (
    .onehot (bus.req_gnt_i),
    .bin    (gnt_idx)
  );

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == cnt_t'(DEPTH));
  assign head  = idx_q[rd_ptr_q];

  assign bus.rsp_ready_o = !empty & bus.rsp_ready_i[head];
  assign bus.rsp_data_o  = DATA_W'(bus.rsp_data_i);
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.count_o     = cnt_q;

  always_comb begin
    bus.rsp_valid_o = '0;
    for (int i = 0; i < N; i++) begin
      bus.rsp_valid_o[i] = bus.rsp_valid_i & !empty & (head == hpdcache_req_idx_t'(i));
    end
  end

  assign pop  = bus.rsp_valid_i & bus.rsp_ready_o & bus.rsp_last_i;
  // A slot freed by a same-cycle pop can take the push, so full+pop+push holds count.
  assign push = bus.req_fire_i & (!full | pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      cnt_q <= cnt_q + cnt_t'(1);
      else if (pop && !push) cnt_q <= cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) idx_q[wr_ptr_q] <= gnt_idx;
  end

`ifdef HPDCACHE_RSP_DEMUX_CHECK_EN
  logic err_q;
  logic stall_q;

  // A single stalled cycle is legal: it covers a response racing the push into an empty tracker.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      stall_q <= bus.rsp_valid_i & empty;
      if ((bus.req_fire_i & full & !pop) ||
          (bus.req_fire_i & !$onehot(bus.req_gnt_i)) ||
          (bus.rsp_valid_i & empty & stall_q)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err_o = err_q;

  a_rsp_valid_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.rsp_valid_o));
  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.count_o <= cnt_t'(DEPTH));
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hpdcache_rsp_demux.sv
// Directed vector bench for hpdcache_rsp_demux (N=4, DEPTH=4).
module tb_hpdcache_rsp_demux;
  localparam int N      = 4;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = $clog2(DEPTH + 1);
`ifdef HPDCACHE_RSP_DEMUX_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hpdcache_rsp_demux_if #(.N(N), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

  hpdcache_rsp_demux #(.N(N), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [N-1:0]      gnt;
    logic              fire;
    logic              rvld;
    logic              rlast;
    logic [N-1:0]      rrdy;
    logic [DATA_W-1:0] dat;
    logic [N-1:0]      e_vld;
    logic              e_rdy;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_full;
    logic              e_empty;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic [N-1:0] gnt, input logic fire, rvld, rlast,
                              input logic [N-1:0] rrdy, input logic [DATA_W-1:0] dat,
                              input logic [N-1:0] e_vld, input logic e_rdy,
                              input int e_cnt, input logic e_full, e_empty);
    vec_t v;
    v.gnt = gnt; v.fire = fire; v.rvld = rvld; v.rlast = rlast; v.rrdy = rrdy; v.dat = dat;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.e_cnt = CNT_W'(e_cnt);
    v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic drive(input logic [N-1:0] gnt, input logic fire, rvld, rlast,
                       input logic [N-1:0] rrdy, input logic [DATA_W-1:0] dat);
    @(posedge clk);
    #1;
    bus.req_gnt_i   = gnt;
    bus.req_fire_i  = fire;
    bus.rsp_valid_i = rvld;
    bus.rsp_last_i  = rlast;
    bus.rsp_ready_i = rrdy;
    bus.rsp_data_i  = dat;
    @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [N-1:0] e_vld, input logic e_rdy,
                           input int e_cnt, input logic e_full, e_empty);
    chk({tag, ".rsp_valid_o"}, 64'(bus.rsp_valid_o), 64'(e_vld));
    chk({tag, ".rsp_ready_o"}, 64'(bus.rsp_ready_o), 64'(e_rdy));
    chk({tag, ".count_o"},     64'(bus.count_o),     64'(e_cnt));
    chk({tag, ".full_o"},      64'(bus.full_o),      64'(e_full));
    chk({tag, ".empty_o"},     64'(bus.empty_o),     64'(e_empty));
  endtask

  initial begin
    // Ordered responses, count 3->2->1->0
    vecs.push_back(mk(4'b0010, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk(4'b1000, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0001, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 2, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hD0, 4'b0010, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hD1, 4'b1000, 1, 2, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hD2, 4'b0001, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'hF, 64'h0,  4'b0000, 0, 0, 0, 1));
    // Three-beat response to requester 2, beat 2 backpressured
    vecs.push_back(mk(4'b0100, 1, 0, 0, 4'hF,    64'h0,  4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 4'hF,    64'hB0, 4'b0100, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 4'b1011, 64'hB1, 4'b0100, 0, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 0, 4'hF,    64'hB1, 4'b0100, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF,    64'hB2, 4'b0100, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'hF,    64'h0,  4'b0000, 0, 0, 0, 1));
    // Fill, pop+push at full, alternate with wrap, drain
    vecs.push_back(mk(4'b0001, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 0, 0, 0, 1));
    vecs.push_back(mk(4'b0010, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 2, 0, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0010, 1, 1, 1, 4'hF, 64'hE0, 4'b0001, 1, 4, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE1, 4'b0010, 1, 4, 1, 0));
    vecs.push_back(mk(4'b1000, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE2, 4'b0100, 1, 4, 1, 0));
    vecs.push_back(mk(4'b0001, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE3, 4'b1000, 1, 4, 1, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 0, 4'hF, 64'h0,  4'b0000, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE4, 4'b0010, 1, 4, 1, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE5, 4'b1000, 1, 3, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE6, 4'b0001, 1, 2, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 1, 1, 4'hF, 64'hE7, 4'b0100, 1, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 4'hF, 64'h0,  4'b0000, 0, 0, 0, 1));

    // Reset held 3 cycles with a response pending upstream
    rst = 1'b1;
    bus.req_gnt_i   = '0;
    bus.req_fire_i  = 1'b0;
    bus.rsp_valid_i = 1'b1;
    bus.rsp_last_i  = 1'b1;
    bus.rsp_ready_i = 4'hF;
    bus.rsp_data_i  = 64'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_state("reset", 4'b0000, 0, 0, 0, 1);
    chk("reset.err_o", 64'(bus.err_o), 64'h0);
    chk("reset.rsp_data_o", bus.rsp_data_o, 64'hA5);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.rsp_valid_i = 1'b0;

    foreach (vecs[k]) begin
      drive(vecs[k].gnt, vecs[k].fire, vecs[k].rvld, vecs[k].rlast, vecs[k].rrdy, vecs[k].dat);
      chk_state($sformatf("vec%0d", k), vecs[k].e_vld, vecs[k].e_rdy, vecs[k].e_cnt,
                vecs[k].e_full, vecs[k].e_empty);
      chk($sformatf("vec%0d.rsp_data_o", k), bus.rsp_data_o, vecs[k].dat);
    end
    chk("table.err_o", 64'(bus.err_o), 64'h0);

    // Response racing the push into an empty tracker stalls exactly one cycle
    drive(4'b0100, 1, 1, 1, 4'hF, 64'h55);
    chk_state("race.push", 4'b0000, 0, 0, 0, 1);
    drive(4'b0000, 0, 1, 1, 4'hF, 64'h55);
    chk_state("race.xfer", 4'b0100, 1, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 4'hF, 64'h0);
    chk_state("race.idle", 4'b0000, 0, 0, 0, 1);
    chk("race.err_o", 64'(bus.err_o), 64'h0);

    // Push while full is dropped and flagged
    drive(4'b0001, 1, 0, 0, 4'hF, 64'h0);
    drive(4'b0010, 1, 0, 0, 4'hF, 64'h0);
    drive(4'b0100, 1, 0, 0, 4'hF, 64'h0);
    drive(4'b1000, 1, 0, 0, 4'hF, 64'h0);
    chk("ovf.pre.err_o", 64'(bus.err_o), 64'h0);
    drive(4'b0010, 1, 0, 0, 4'hF, 64'h0);
    chk_state("ovf.push", 4'b0000, 1, 4, 1, 0);
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hF0);
    chk_state("ovf.pop0", 4'b0001, 1, 4, 1, 0);
    chk("ovf.err_o", 64'(bus.err_o), 64'(ERR_EN));
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hF1);
    chk_state("ovf.pop1", 4'b0010, 1, 3, 0, 0);
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hF2);
    chk_state("ovf.pop2", 4'b0100, 1, 2, 0, 0);
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hF3);
    chk_state("ovf.pop3", 4'b1000, 1, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 4'hF, 64'h0);
    chk_state("ovf.drained", 4'b0000, 0, 0, 0, 1);
    chk("ovf.sticky.err_o", 64'(bus.err_o), 64'(ERR_EN));

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst2.err_o", 64'(bus.err_o), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Malformed grants encode to lowest set bit, or 0 when none set
    drive(4'b0110, 1, 0, 0, 4'hF, 64'h0);
    drive(4'b0000, 1, 0, 0, 4'hF, 64'h0);
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hC0);
    chk_state("bad.rsp0", 4'b0010, 1, 2, 0, 0);
    chk("bad.err_o", 64'(bus.err_o), 64'(ERR_EN));
    drive(4'b0000, 0, 1, 1, 4'hF, 64'hC1);
    chk_state("bad.rsp1", 4'b0001, 1, 1, 0, 0);
    drive(4'b0000, 0, 0, 0, 4'hF, 64'h0);
    chk_state("bad.idle", 4'b0000, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
